// File: rtl/ssd_pkg.sv
// Shared segment constants, glyph lookup and FSM state type for the
// seven-segment scan driver.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  // Active-low {a,b,c,d,e,f,g} glyphs, entry 15 (F) first down to entry 0.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEX,
    ST_CONV,
    ST_COMMIT
  } state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_GLYPHS[nibble];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: DATA_W shift/add-3 steps after start,
// with overflow when the value needs more than NUM_DIGITS decimal digits.
module bin2bcd_seq #(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [DATA_W-1:0]       value_i,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic                    ovf_o
);

  localparam int BCD_W = 4 * NUM_DIGITS + 4;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sticky_q, sticky_d;
  logic [BCD_W-1:0]  adjusted;

  always_comb begin
    adjusted = bcd_q;
    for (int i = 0; i <= NUM_DIGITS; i++) begin
      if (adjusted[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = adjusted[4*i +: 4] + 4'd3;
      end
    end

    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (start_i) begin
      bin_d    = value_i;
      bcd_d    = '0;
      cnt_d    = CNT_W'(DATA_W);
      sticky_d = 1'b0;
    end else if (cnt_q != '0) begin
      // A bit pushed out of the guard digit means the value is far too large.
      bcd_d    = {adjusted[BCD_W-2:0], bin_q[DATA_W-1]};
      bin_d    = bin_q << 1;
      cnt_d    = cnt_q - 1'b1;
      sticky_d = sticky_q | adjusted[BCD_W-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  // High during the cycle that performs the final shift.
  assign done_o = (cnt_q == CNT_W'(1));
  assign bcd_o  = bcd_q[4*NUM_DIGITS-1:0];
  assign ovf_o  = sticky_q | (|bcd_q[BCD_W-1 -: 4]);

endmodule

// File: rtl/ssd_scan_driver.sv
// Multi-digit seven-segment scan driver with hex/decimal display, leading-zero
// blanking, per-digit decimal points and overflow dashes.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DATA_W     = 16,
  parameter int SCAN_DIV_W = 18
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_W-1:0]     value_i,
  input  logic                  load_i,
  input  logic                  mode_i,
  input  logic                  blank_lz_i,
  input  logic [NUM_DIGITS-1:0] dp_mask_i,
  input  logic                  enable_i,
  output logic [NUM_DIGITS-1:0] anode_o,
  output logic [7:0]            cathode_o,
  output logic                  busy_o,
  output logic                  overflow_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int EXT_W = (DATA_W > 4 * NUM_DIGITS) ? DATA_W : 4 * NUM_DIGITS;

  state_e state_q, state_d;
  logic [DATA_W-1:0]           value_q;
  logic                        pendBlank_q;
  logic [NUM_DIGITS-1:0][3:0]  digitBuf_q, digitBuf_d;
  logic                        blank_q, blank_d;
  logic                        overflow_q, overflow_d;
  logic                        busy_q;
  logic [SCAN_DIV_W-1:0]       scanCnt_q;
  logic [IDX_W-1:0]            index_q, index_d;
  logic [NUM_DIGITS-1:0]       anode_q, anode_d;
  logic [7:0]                  cathode_q, cathode_d;

  logic                        loadAccept;
  logic                        commitHex;
  logic                        commitBcd;
  logic                        bcdDone;
  logic                        bcdOvf;
  logic [4*NUM_DIGITS-1:0]     bcdDigits;
  logic [EXT_W-1:0]            valueExt;
  logic [NUM_DIGITS-1:0]       zeroFrom;
  logic                        zeroRun;
  logic [6:0]                  seg;

  assign loadAccept = load_i && (state_q == ST_IDLE) && !busy_q;
  assign valueExt   = EXT_W'(value_q);

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (loadAccept && mode_i),
    .value_i (value_i),
    .done_o  (bcdDone),
    .bcd_o   (bcdDigits),
    .ovf_o   (bcdOvf)
  );

  always_comb begin
    state_d   = state_q;
    commitHex = 1'b0;
    commitBcd = 1'b0;
    case (state_q)
      ST_IDLE:   if (loadAccept) state_d = mode_i ? ST_CONV : ST_HEX;
      ST_HEX: begin
        commitHex = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_CONV:   if (bcdDone) state_d = ST_COMMIT;
      ST_COMMIT: begin
        commitBcd = 1'b1;
        state_d   = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // The displayed buffer only changes here, so a conversion never shows a partial result.
  always_comb begin
    digitBuf_d = digitBuf_q;
    blank_d    = blank_q;
    overflow_d = overflow_q;
    if (commitHex) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digitBuf_d[i] = valueExt[4*i +: 4];
      end
      overflow_d = |(valueExt >> (4 * NUM_DIGITS));
      blank_d    = pendBlank_q;
    end else if (commitBcd) begin
      digitBuf_d = bcdDigits;
      overflow_d = bcdOvf;
      blank_d    = pendBlank_q;
    end
  end

  always_comb begin
    index_d = index_q;
    if (&scanCnt_q) begin
      index_d = (index_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : index_q + 1'b1;
    end

    zeroFrom = '0;
    zeroRun  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zeroRun     = zeroRun & (digitBuf_q[i] == 4'd0);
      zeroFrom[i] = zeroRun;
    end

    if (overflow_q) begin
      seg = SEG_DASH;
    end else if (blank_q && (index_q != '0) && zeroFrom[index_q]) begin
      seg = SEG_BLANK;
    end else begin
      seg = hex_to_seg(digitBuf_q[index_q]);
    end

    cathode_d = {seg, ~dp_mask_i[index_q]};
    anode_d   = enable_i ? ~(NUM_DIGITS'(1) << index_q) : '1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      value_q     <= '0;
      pendBlank_q <= 1'b0;
      digitBuf_q  <= '0;
      blank_q     <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      scanCnt_q   <= '0;
      index_q     <= '0;
      anode_q     <= '1;
      cathode_q   <= 8'hFF;
    end else begin
      state_q     <= state_d;
      if (loadAccept) begin
        value_q     <= value_i;
        pendBlank_q <= blank_lz_i;
      end
      digitBuf_q  <= digitBuf_d;
      blank_q     <= blank_d;
      overflow_q  <= overflow_d;
      busy_q      <= (state_q == ST_CONV) || (state_q == ST_COMMIT);
      scanCnt_q   <= scanCnt_q + 1'b1;
      index_q     <= index_d;
      anode_q     <= anode_d;
      cathode_q   <= cathode_d;
    end
  end

  assign anode_o    = anode_q;
  assign cathode_o  = cathode_q;
  assign busy_o     = busy_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed table-driven bench for ssd_scan_driver with 4 digits and a
// 4-clock digit period.
module tb_ssd_scan_driver;

  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   value;
  logic          load;
  logic          mode;
  logic          blankLz;
  logic [ND-1:0] dpMask;
  logic          enable;
  logic [ND-1:0] anode;
  logic [7:0]    cathode;
  logic          busy;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0]      value;
    logic             mode;
    logic             blank;
    logic [3:0]       dp;
    logic [3:0][7:0]  expCath;
    logic             expOvf;
  } vec_t;

  vec_t vecs[7];

  ssd_scan_driver #(
    .NUM_DIGITS (ND),
    .DATA_W     (16),
    .SCAN_DIV_W (2)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .value_i    (value),
    .load_i     (load),
    .mode_i     (mode),
    .blank_lz_i (blankLz),
    .dp_mask_i  (dpMask),
    .enable_i   (enable),
    .anode_o    (anode),
    .cathode_o  (cathode),
    .busy_o     (busy),
    .overflow_o (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Waits until digit k is selected, then returns its cathode pattern.
  task automatic waitDigit(input int k, output logic [7:0] cath);
    logic [3:0] want;
    bit found;
    want  = ~(4'b0001 << k);
    found = 1'b0;
    cath  = 8'hxx;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (anode === want) begin
        cath  = cathode;
        found = 1'b1;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL digit%0d_timeout: anode %b never reached %b", k, anode, want);
    end
  endtask

  // Pulses load for one cycle and returns how many cycles busy was high.
  task automatic applyStimulus(input logic [15:0] v, input logic m, input logic b,
                               input logic [3:0] dp, input int midLoadAt, output int busyCycles);
    @(negedge clk);
    value   = v;
    mode    = m;
    blankLz = b;
    dpMask  = dp;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    busyCycles = 0;
    for (int c = 0; c < 25; c++) begin
      if (c == midLoadAt) begin
        value = 16'd9;
        mode  = 1'b1;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      if (busy) busyCycles++;
    end
    load = 1'b0;
  endtask

  initial begin
    logic [7:0] cath;
    int busyCycles;
    bit allOff;

    vecs[0] = '{16'hBEEF, 1'b0, 1'b0, 4'b0000, {8'b11000001, 8'b01100001, 8'b01100001, 8'b01110001}, 1'b0};
    vecs[1] = '{16'd1234, 1'b1, 1'b0, 4'b0000, {8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001}, 1'b0};
    vecs[2] = '{16'd12345, 1'b1, 1'b0, 4'b0000, {8'b11111101, 8'b11111101, 8'b11111101, 8'b11111101}, 1'b1};
    vecs[3] = '{16'h0012, 1'b0, 1'b0, 4'b0000, {8'b00000011, 8'b00000011, 8'b10011111, 8'b00100101}, 1'b0};
    vecs[4] = '{16'd7, 1'b1, 1'b1, 4'b0010, {8'b11111111, 8'b11111111, 8'b11111110, 8'b00011111}, 1'b0};
    vecs[5] = '{16'h0A05, 1'b0, 1'b1, 4'b1000, {8'b11111110, 8'b00010001, 8'b00000011, 8'b01001001}, 1'b0};
    vecs[6] = '{16'd9999, 1'b1, 1'b0, 4'b0000, {8'b00001001, 8'b00001001, 8'b00001001, 8'b00001001}, 1'b0};

    rst_n   = 1'b0;
    value   = '0;
    load    = 1'b0;
    mode    = 1'b0;
    blankLz = 1'b0;
    dpMask  = '0;
    enable  = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("reset_anode", 32'(anode), 32'h0000000F);
    checkOutput("reset_cathode", 32'(cathode), 32'h000000FF);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_overflow", 32'(overflow), 32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("release_anode", 32'(anode), 32'h0000000F);
    waitDigit(0, cath);
    checkOutput("reset_digit0", 32'(cath), 32'h00000003);

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].value, vecs[v].mode, vecs[v].blank, vecs[v].dp, -1, busyCycles);
      checkOutput($sformatf("vec%0d_busy", v), 32'(busyCycles), vecs[v].mode ? 32'd17 : 32'd0);
      checkOutput($sformatf("vec%0d_ovf", v), 32'(overflow), 32'(vecs[v].expOvf));
      for (int d = 0; d < ND; d++) begin
        waitDigit(d, cath);
        checkOutput($sformatf("vec%0d_digit%0d", v, d), 32'(cath), 32'(vecs[v].expCath[d]));
      end
    end

    // A second load arriving mid-conversion must leave the 1234 result intact.
    applyStimulus(16'd1234, 1'b1, 1'b0, 4'b0000, 5, busyCycles);
    checkOutput("midload_busy", 32'(busyCycles), 32'd17);
    waitDigit(0, cath);
    checkOutput("midload_digit0", 32'(cath), 32'h00000099);
    waitDigit(3, cath);
    checkOutput("midload_digit3", 32'(cath), 32'h0000009F);

    // Reset during the eighth conversion cycle of 9999.
    @(negedge clk);
    value = 16'd9999;
    mode  = 1'b1;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (7) @(negedge clk);
    rst_n  = 1'b0;
    enable = 1'b0;
    dpMask = '0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_overflow", 32'(overflow), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    allOff = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (anode !== 4'b1111) allOff = 1'b0;
    end
    checkOutput("disabled_anode", 32'(allOff), 32'h1);
    enable = 1'b1;
    @(negedge clk);
    checkOutput("index_advanced", 32'(anode), 32'h0000000B);
    repeat (20) @(negedge clk);
    checkOutput("abort_busy_later", 32'(busy), 32'h0);
    for (int d = 0; d < ND; d++) begin
      waitDigit(d, cath);
      checkOutput($sformatf("abort_digit%0d", d), 32'(cath), 32'h00000003);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
